// File: rtl/ptw_arbiter_pkg.sv
// ptw_arbiter_pkg: shared types and constants for the page-table-walker arbiter.
//   arb_state_t   : arbiter FSM states
//   req_id_t      : translation requester identity (instruction fetch / data access)
//   PAGE_OFFSET_W : page offset width; VPN/PPN occupy bits 63:PAGE_OFFSET_W
package ptw_arbiter_pkg;

  localparam int PAGE_OFFSET_W = 12;
  localparam int VPN_W         = 64 - PAGE_OFFSET_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_t;

endpackage

// File: rtl/ptw_arbiter_if.sv
// ptw_arbiter_if: requester and walker signals of the PTW arbiter.
//   i_* / d_*   : instruction-fetch / data-access request and response
//   flush       : invalidate last-hit buffers (sfence.vma / satp write)
//   walk_*      : page-table walker start / VA / completion / result
// Modports: slave = the arbiter, master = the requesters plus walker around it.
interface ptw_arbiter_if;

  logic        i_req;
  logic [63:0] i_va;
  logic        i_rsp_valid;
  logic [63:0] i_rsp_pa;
  logic        i_rsp_fault;

  logic        d_req;
  logic [63:0] d_va;
  logic        d_rsp_valid;
  logic [63:0] d_rsp_pa;
  logic        d_rsp_fault;

  logic        flush;

  logic        walk_en;
  logic [63:0] walk_va;
  logic        walk_done;
  logic        walk_valid;
  logic [63:0] walk_pa;

  modport slave (
    input  i_req, i_va, d_req, d_va, flush, walk_done, walk_valid, walk_pa,
    output i_rsp_valid, i_rsp_pa, i_rsp_fault,
    output d_rsp_valid, d_rsp_pa, d_rsp_fault,
    output walk_en, walk_va
  );

  modport master (
    output i_req, i_va, d_req, d_va, flush, walk_done, walk_valid, walk_pa,
    input  i_rsp_valid, i_rsp_pa, i_rsp_fault,
    input  d_rsp_valid, d_rsp_pa, d_rsp_fault,
    input  walk_en, walk_va
  );

endinterface

// File: rtl/ptw_lasthit.sv
// ptw_lasthit: one-entry last translation buffer {valid, vpn, ppn}.
//   clk, reset     : clock, synchronous active-high reset
//   flush          : invalidate the entry (wins over a same-cycle write)
//   wr_en/wr_vpn/wr_ppn : install a completed translation
//   lk_vpn         : lookup VPN; hit/hit_ppn are combinational from the entry
module ptw_lasthit
  import ptw_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [VPN_W-1:0] wr_vpn,
  input  logic [VPN_W-1:0] wr_ppn,
  input  logic [VPN_W-1:0] lk_vpn,
  output logic             hit,
  output logic [VPN_W-1:0] hit_ppn
);

  logic             valid_q, valid_d;
  logic [VPN_W-1:0] vpn_q, vpn_d;
  logic [VPN_W-1:0] ppn_q, ppn_d;

  always_comb begin
    valid_d = valid_q;
    vpn_d   = vpn_q;
    ppn_d   = ppn_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (wr_en) begin
      valid_d = 1'b1;
      vpn_d   = wr_vpn;
      ppn_d   = wr_ppn;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      vpn_q   <= '0;
      ppn_q   <= '0;
    end else begin
      valid_q <= valid_d;
      vpn_q   <= vpn_d;
      ppn_q   <= ppn_d;
    end
  end

  assign hit     = valid_q && (lk_vpn == vpn_q);
  assign hit_ppn = ppn_q;

endmodule

// File: rtl/ptw_arbiter.sv
// ptw_arbiter: shares one page-table walker between the instruction-fetch and
// data-access translation requesters, one request at a time, round-robin on
// conflict, returning a one-cycle response to the granted requester.
//   clk, reset : clock, synchronous active-high reset
//   bus        : ptw_arbiter_if.slave (requests, responses, flush, walker pins)
// Build option: define PTW_ARB_LASTHIT_EN to add a one-entry last-hit buffer
// per requester that answers repeated same-page translations without a walk.
//
// state | meaning
// IDLE  | arbitrate requests; on buffer hit go straight to RESP
// ISSUE | walk_en pulse; bare path completes here when walk_done is high
// WAIT  | hold walk_va, capture walk_pa on walk_valid until walk_done
// RESP  | one-cycle response to the granted requester, update round-robin
module ptw_arbiter
  import ptw_arbiter_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  ptw_arbiter_if.slave   bus
);

  arb_state_t  state_q, state_d;
  req_id_t     id_q, id_d;
  req_id_t     last_q, last_d;
  logic [63:0] cur_va_q, cur_va_d;
  logic [63:0] cur_pa_q, cur_pa_d;
  logic        ok_q, ok_d;

  logic             grant_i, grant_d, gnt_hit;
  logic [VPN_W-1:0] gnt_hit_ppn;
  logic             i_hit, d_hit;
  logic [VPN_W-1:0] i_hit_ppn, d_hit_ppn;

  logic        walk_en, i_rsp_valid, d_rsp_valid, i_rsp_fault, d_rsp_fault;
  logic [63:0] walk_va, i_rsp_pa, d_rsp_pa;

`ifdef PTW_ARB_LASTHIT_EN
  // Tracks any flush between grant and response so a stale result is not cached.
  logic flushed_q, flushed_d;
  logic lh_wr, i_hit_raw, d_hit_raw;

  always_comb begin
    flushed_d = (state_q == IDLE) ? bus.flush : (flushed_q | bus.flush);
  end

  always_ff @(posedge clk) begin
    if (reset) flushed_q <= 1'b0;
    else       flushed_q <= flushed_d;
  end

  assign lh_wr = (state_q == RESP) && ok_q && !flushed_q && !bus.flush;

  ptw_lasthit u_lasthit_i (
    .clk     (clk),
    .reset   (reset),
    .flush   (bus.flush),
    .wr_en   (lh_wr && (id_q == REQ_I)),
    .wr_vpn  (cur_va_q[63:PAGE_OFFSET_W]),
    .wr_ppn  (cur_pa_q[63:PAGE_OFFSET_W]),
    .lk_vpn  (bus.i_va[63:PAGE_OFFSET_W]),
    .hit     (i_hit_raw),
    .hit_ppn (i_hit_ppn)
  );

  ptw_lasthit u_lasthit_d (
    .clk     (clk),
    .reset   (reset),
    .flush   (bus.flush),
    .wr_en   (lh_wr && (id_q == REQ_D)),
    .wr_vpn  (cur_va_q[63:PAGE_OFFSET_W]),
    .wr_ppn  (cur_pa_q[63:PAGE_OFFSET_W]),
    .lk_vpn  (bus.d_va[63:PAGE_OFFSET_W]),
    .hit     (d_hit_raw),
    .hit_ppn (d_hit_ppn)
  );

  // A flush in the grant cycle empties the buffer at this edge, so do not trust its hit.
  assign i_hit = i_hit_raw && !bus.flush;
  assign d_hit = d_hit_raw && !bus.flush;
`else
  assign i_hit     = 1'b0;
  assign d_hit     = 1'b0;
  assign i_hit_ppn = '0;
  assign d_hit_ppn = '0;
`endif

  // Round-robin: on conflict the requester not served last wins.
  always_comb begin
    grant_i     = bus.i_req && (!bus.d_req || (last_q == REQ_D));
    grant_d     = bus.d_req && !grant_i;
    gnt_hit     = (grant_i && i_hit) || (grant_d && d_hit);
    gnt_hit_ppn = grant_i ? i_hit_ppn : d_hit_ppn;
  end

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    last_d      = last_q;
    cur_va_d    = cur_va_q;
    cur_pa_d    = cur_pa_q;
    ok_d        = ok_q;
    walk_en     = 1'b0;
    walk_va     = '0;
    i_rsp_valid = 1'b0;
    i_rsp_pa    = '0;
    i_rsp_fault = 1'b0;
    d_rsp_valid = 1'b0;
    d_rsp_pa    = '0;
    d_rsp_fault = 1'b0;
    case (state_q)
      IDLE: begin
        ok_d     = 1'b0;
        cur_pa_d = '0;
        if (grant_i || grant_d) begin
          id_d     = grant_i ? REQ_I : REQ_D;
          cur_va_d = grant_i ? bus.i_va : bus.d_va;
          if (gnt_hit) begin
            state_d  = RESP;
            ok_d     = 1'b1;
            cur_pa_d = {gnt_hit_ppn, cur_va_d[PAGE_OFFSET_W-1:0]};
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        walk_en = 1'b1;
        walk_va = cur_va_q;
        if (bus.walk_valid) begin
          cur_pa_d = bus.walk_pa;
          ok_d     = 1'b1;
        end
        state_d = bus.walk_done ? RESP : WAIT;
      end
      WAIT: begin
        walk_va = cur_va_q;
        if (bus.walk_valid) begin
          cur_pa_d = bus.walk_pa;
          ok_d     = 1'b1;
        end
        if (bus.walk_done) state_d = RESP;
      end
      RESP: begin
        if (id_q == REQ_I) begin
          i_rsp_valid = 1'b1;
          i_rsp_pa    = ok_q ? cur_pa_q : '0;
          i_rsp_fault = !ok_q;
        end else begin
          d_rsp_valid = 1'b1;
          d_rsp_pa    = ok_q ? cur_pa_q : '0;
          d_rsp_fault = !ok_q;
        end
        last_d  = id_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      id_q     <= REQ_I;
      last_q   <= REQ_D;
      cur_va_q <= '0;
      cur_pa_q <= '0;
      ok_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      last_q   <= last_d;
      cur_va_q <= cur_va_d;
      cur_pa_q <= cur_pa_d;
      ok_q     <= ok_d;
    end
  end

  assign bus.walk_en     = walk_en;
  assign bus.walk_va     = walk_va;
  assign bus.i_rsp_valid = i_rsp_valid;
  assign bus.i_rsp_pa    = i_rsp_pa;
  assign bus.i_rsp_fault = i_rsp_fault;
  assign bus.d_rsp_valid = d_rsp_valid;
  assign bus.d_rsp_pa    = d_rsp_pa;
  assign bus.d_rsp_fault = d_rsp_fault;

endmodule

// File: tb/tb_ptw_arbiter.sv
// tb_ptw_arbiter: directed, table-driven bench for ptw_arbiter.
// Define PTW_ARB_LASTHIT_EN to also exercise the last-hit buffers.
module tb_ptw_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ptw_arbiter_if bus();

  ptw_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Walker model: bare mode answers in the ISSUE cycle with pa=va, otherwise
  // the bench drives done/valid/pa cycle by cycle.
  logic        bare_mode = 1'b0;
  logic        drv_done  = 1'b1;
  logic        drv_valid = 1'b0;
  logic [63:0] drv_pa    = '0;

  assign bus.walk_done  = bare_mode ? 1'b1        : drv_done;
  assign bus.walk_valid = bare_mode ? bus.walk_en : drv_valid;
  assign bus.walk_pa    = bare_mode ? bus.walk_va : drv_pa;

  int errors = 0;
  int checks = 0;
  int wen_cnt = 0;
  int irsp_cnt = 0;
  int drsp_cnt = 0;

  always @(posedge clk) begin
    if (bus.walk_en === 1'b1)     wen_cnt++;
    if (bus.i_rsp_valid === 1'b1) irsp_cnt++;
    if (bus.d_rsp_valid === 1'b1) drsp_cnt++;
  end

  typedef struct {
    logic        is_d;
    logic [63:0] va;
    int          lat;   // cycles after ISSUE until walk_done (0 = done in ISSUE)
    int          vat;   // cycle index of walk_valid (0 = ISSUE, -1 = never)
    logic [63:0] wpa;
    logic        exp_fault;
    logic [63:0] exp_pa;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_walk_en"},  {63'd0, bus.walk_en}, 64'd0);
    chk({tag, "_walk_va"},  bus.walk_va, 64'd0);
    chk({tag, "_i_valid"},  {63'd0, bus.i_rsp_valid}, 64'd0);
    chk({tag, "_i_pa"},     bus.i_rsp_pa, 64'd0);
    chk({tag, "_i_fault"},  {63'd0, bus.i_rsp_fault}, 64'd0);
    chk({tag, "_d_valid"},  {63'd0, bus.d_rsp_valid}, 64'd0);
    chk({tag, "_d_pa"},     bus.d_rsp_pa, 64'd0);
    chk({tag, "_d_fault"},  {63'd0, bus.d_rsp_fault}, 64'd0);
  endtask

  // One isolated walk: request, ISSUE, lat WAIT cycles, RESP the cycle after done.
  task automatic run_txn(input int idx, input vec_t v);
    int wen0;
    logic own_v, oth_v, own_f;
    logic [63:0] own_pa;
    wen0 = wen_cnt;
    bare_mode = 1'b0; drv_done = 1'b1; drv_valid = 1'b0;
    @(negedge clk);
    if (v.is_d) begin bus.d_req = 1'b1; bus.d_va = v.va; end
    else        begin bus.i_req = 1'b1; bus.i_va = v.va; end
    @(negedge clk);
    chk($sformatf("v%0d_issue_walk_en", idx), {63'd0, bus.walk_en}, 64'd1);
    chk($sformatf("v%0d_issue_walk_va", idx), bus.walk_va, v.va);
    drv_done = (v.lat == 0); drv_valid = (v.vat == 0); drv_pa = v.wpa;
    for (int k = 1; k <= v.lat; k++) begin
      @(negedge clk);
      chk($sformatf("v%0d_wait%0d_walk_en", idx, k), {63'd0, bus.walk_en}, 64'd0);
      chk($sformatf("v%0d_wait%0d_walk_va", idx, k), bus.walk_va, v.va);
      drv_done = (k == v.lat); drv_valid = (k == v.vat);
    end
    @(negedge clk);
    drv_done = 1'b1; drv_valid = 1'b0;
    own_v  = v.is_d ? bus.d_rsp_valid : bus.i_rsp_valid;
    oth_v  = v.is_d ? bus.i_rsp_valid : bus.d_rsp_valid;
    own_f  = v.is_d ? bus.d_rsp_fault : bus.i_rsp_fault;
    own_pa = v.is_d ? bus.d_rsp_pa    : bus.i_rsp_pa;
    chk($sformatf("v%0d_rsp_valid", idx), {63'd0, own_v}, 64'd1);
    chk($sformatf("v%0d_other_valid", idx), {63'd0, oth_v}, 64'd0);
    chk($sformatf("v%0d_rsp_pa", idx), own_pa, v.exp_pa);
    chk($sformatf("v%0d_rsp_fault", idx), {63'd0, own_f}, {63'd0, v.exp_fault});
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    @(negedge clk);
    own_v = v.is_d ? bus.d_rsp_valid : bus.i_rsp_valid;
    chk($sformatf("v%0d_rsp_one_cycle", idx), {63'd0, own_v}, 64'd0);
    chk($sformatf("v%0d_walk_en_pulses", idx), 64'(wen_cnt - wen0), 64'd1);
  endtask

  initial begin
    int got_id[$];
    int got_cyc[$];
    int i0, d0;
    vec_t lv;

    vecs[0] = '{1'b0, 64'h0000_0000_1234_5678, 0,  0, 64'h0000_0000_1234_5678, 1'b0, 64'h0000_0000_1234_5678};
    vecs[1] = '{1'b1, 64'h0000_0040_0000_1234, 3,  1, 64'h0000_0000_8000_1234, 1'b0, 64'h0000_0000_8000_1234};
    vecs[2] = '{1'b0, 64'h0000_0000_0000_5000, 2, -1, 64'h0000_0000_7777_7000, 1'b1, 64'h0};
    vecs[3] = '{1'b1, 64'h0000_0000_0009_9ABC, 0, -1, 64'h1111_2222_3333_4444, 1'b1, 64'h0};
    vecs[4] = '{1'b0, 64'hFFFF_FFC0_0000_0FF0, 1,  0, 64'h0000_00AB_CDEF_0FF0, 1'b0, 64'h0000_00AB_CDEF_0FF0};
    vecs[5] = '{1'b1, 64'h0000_0012_3456_7ABC, 4,  2, 64'hDEAD_BEEF_0000_0ABC, 1'b0, 64'hDEAD_BEEF_0000_0ABC};

    bus.i_req = 1'b0; bus.i_va = '0;
    bus.d_req = 1'b0; bus.d_va = '0;
    bus.flush = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;

    // Simultaneous requests after reset, bare mode: I first (T+2), D at T+5.
    bare_mode = 1'b1;
    bus.i_req = 1'b1; bus.i_va = 64'h0000_0000_0000_A123;
    bus.d_req = 1'b1; bus.d_va = 64'h0000_0000_0000_B456;
    @(negedge clk);
    chk("t1_issue_walk_en", {63'd0, bus.walk_en}, 64'd1);
    chk("t1_issue_walk_va", bus.walk_va, 64'h0000_0000_0000_A123);
    @(negedge clk);
    chk("t1_i_rsp_valid", {63'd0, bus.i_rsp_valid}, 64'd1);
    chk("t1_i_rsp_pa", bus.i_rsp_pa, 64'h0000_0000_0000_A123);
    chk("t1_i_rsp_fault", {63'd0, bus.i_rsp_fault}, 64'd0);
    chk("t1_d_quiet", {63'd0, bus.d_rsp_valid}, 64'd0);
    bus.i_req = 1'b0;
    @(negedge clk);
    chk("t1_idle_walk_en", {63'd0, bus.walk_en}, 64'd0);
    @(negedge clk);
    chk("t1_d_issue_walk_en", {63'd0, bus.walk_en}, 64'd1);
    chk("t1_d_issue_walk_va", bus.walk_va, 64'h0000_0000_0000_B456);
    @(negedge clk);
    chk("t1_d_rsp_valid", {63'd0, bus.d_rsp_valid}, 64'd1);
    chk("t1_d_rsp_pa", bus.d_rsp_pa, 64'h0000_0000_0000_B456);
    chk("t1_i_quiet", {63'd0, bus.i_rsp_valid}, 64'd0);
    bus.d_req = 1'b0;
    @(negedge clk);
    bare_mode = 1'b0;

    for (int v = 0; v < 6; v++) run_txn(v, vecs[v]);

    // Both held for four responses; last served was D, so order is I, D, I, D.
    bare_mode = 1'b1;
    bus.i_req = 1'b1; bus.i_va = 64'h0000_0000_0000_C000;
    bus.d_req = 1'b1; bus.d_va = 64'h0000_0000_0000_D000;
    for (int c = 0; c < 40 && got_id.size() < 4; c++) begin
      @(negedge clk);
      chk($sformatf("rr_c%0d_not_both", c), {63'd0, bus.i_rsp_valid & bus.d_rsp_valid}, 64'd0);
      if (bus.i_rsp_valid === 1'b1) begin
        got_id.push_back(0); got_cyc.push_back(c);
        chk("rr_i_pa", bus.i_rsp_pa, 64'h0000_0000_0000_C000);
      end else if (bus.d_rsp_valid === 1'b1) begin
        got_id.push_back(1); got_cyc.push_back(c);
        chk("rr_d_pa", bus.d_rsp_pa, 64'h0000_0000_0000_D000);
      end
      if (got_id.size() == 4) begin bus.i_req = 1'b0; bus.d_req = 1'b0; end
    end
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    chk("rr_count", 64'(got_id.size()), 64'd4);
    for (int k = 0; k < got_id.size(); k++) begin
      chk($sformatf("rr_order%0d", k), 64'(got_id[k]), 64'(k % 2));
      if (k > 0) chk($sformatf("rr_gap%0d", k), 64'(got_cyc[k] - got_cyc[k-1]), 64'd3);
    end
    @(negedge clk);
    bare_mode = 1'b0;

`ifdef PTW_ARB_LASTHIT_EN
    lv = '{1'b0, 64'h0000_0000_4000_0ABC, 2, 1, 64'h0000_0000_8020_0ABC, 1'b0, 64'h0000_0000_8020_0ABC};
    run_txn(100, lv);
    i0 = wen_cnt;
    @(negedge clk);
    bus.i_req = 1'b1; bus.i_va = 64'h0000_0000_4000_0010;
    @(negedge clk);
    chk("lh_hit_valid", {63'd0, bus.i_rsp_valid}, 64'd1);
    chk("lh_hit_pa", bus.i_rsp_pa, 64'h0000_0000_8020_0010);
    chk("lh_hit_fault", {63'd0, bus.i_rsp_fault}, 64'd0);
    chk("lh_hit_no_walk", {63'd0, bus.walk_en}, 64'd0);
    bus.i_req = 1'b0;
    @(negedge clk);
    chk("lh_hit_one_cycle", {63'd0, bus.i_rsp_valid}, 64'd0);
    chk("lh_hit_walk_cnt", 64'(wen_cnt - i0), 64'd0);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    lv = '{1'b0, 64'h0000_0000_4000_0010, 1, 0, 64'h0000_0000_8020_0010, 1'b0, 64'h0000_0000_8020_0010};
    run_txn(101, lv);
`endif

    // Leave last-granted at I, then abort a D walk with reset from WAIT.
    run_txn(200, vecs[0]);
    bare_mode = 1'b0; drv_done = 1'b1; drv_valid = 1'b0;
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_va = 64'h0000_0000_0077_7000;
    @(negedge clk);
    chk("rst_issue_walk_en", {63'd0, bus.walk_en}, 64'd1);
    drv_done = 1'b0;
    @(negedge clk);
    chk("rst_wait_walk_va", bus.walk_va, 64'h0000_0000_0077_7000);
    @(negedge clk);
    i0 = irsp_cnt; d0 = drsp_cnt;
    reset = 1'b1;
    @(negedge clk);
    chk_all_zero("rst_mid");
    reset = 1'b0; bus.d_req = 1'b0; drv_done = 1'b1;
    repeat (6) @(negedge clk);
    chk("rst_no_i_rsp", 64'(irsp_cnt - i0), 64'd0);
    chk("rst_no_d_rsp", 64'(drsp_cnt - d0), 64'd0);

    // Reset restored last-granted to D: I wins this conflict.
    bare_mode = 1'b1;
    bus.i_req = 1'b1; bus.i_va = 64'h0000_0000_0000_1E00;
    bus.d_req = 1'b1; bus.d_va = 64'h0000_0000_0000_2D00;
    @(negedge clk);
    @(negedge clk);
    chk("rst_rr_i_first", {63'd0, bus.i_rsp_valid}, 64'd1);
    chk("rst_rr_d_waits", {63'd0, bus.d_rsp_valid}, 64'd0);
    bus.i_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rr_d_second", {63'd0, bus.d_rsp_valid}, 64'd1);
    chk("rst_rr_d_pa", bus.d_rsp_pa, 64'h0000_0000_0000_2D00);
    bus.d_req = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
